// File: rtl/add_pipe_nstage.sv
// add_pipe_nstage: WIDTH-bit add/subtract split into STAGES ripple slices,
// one slice per pipeline stage, with a valid/ready handshake on both sides.
//
// Ports:
//   clock, reset_n         rising-edge clock, async active-low reset
//   in_valid / in_ready    operand handshake (in_ready = advance enable)
//   a, b, c_in, sub        operands; sub=1 computes a - b and ignores c_in
//   out_valid / out_ready  result handshake
//   sum, c_out, ovf        result, carry out of MSB, signed overflow

module add_pipe_nstage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int SLICE  = (STAGES > 0) ? WIDTH / STAGES : WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (SLICE * STAGES != WIDTH)) begin : g_bad_cfg
        $error("add_pipe_nstage: WIDTH must be a multiple of STAGES >= 1");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;
    logic             ovf_q;

    // One shared enable: the whole pipe moves or the whole pipe holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the inverted operand is what travels
    // down the skew registers.
    assign b_eff  = sub ? ~b : b;
    assign carry0 = sub | c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0]       op_a;
        logic [SLICE-1:0]       op_b;
        logic                   cin;
        logic                   vin;
        logic [SLICE:0]         add;
        logic [(k+1)*SLICE-1:0] res_d;
        logic [(k+1)*SLICE-1:0] res_q;
        logic                   carry_q;
        logic                   valid_q;

        if (k == 0) begin : g_src
            assign op_a  = a[SLICE-1:0];
            assign op_b  = b_eff[SLICE-1:0];
            assign cin   = carry0;
            assign vin   = in_valid;
            assign res_d = add[SLICE-1:0];
        end else begin : g_src
            assign op_a  = g_stage[k-1].g_ops.a_q[SLICE-1:0];
            assign op_b  = g_stage[k-1].g_ops.b_q[SLICE-1:0];
            assign cin   = g_stage[k-1].carry_q;
            assign vin   = g_stage[k-1].valid_q;
            // New slice goes on top of the lower, already finished slices.
            assign res_d = {add[SLICE-1:0], g_stage[k-1].res_q};
        end

        assign add = {1'b0, op_a} + {1'b0, op_b} + {{SLICE{1'b0}}, cin};

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (adv) begin
                valid_q <= vin;
                carry_q <= add[SLICE];
                res_q   <= res_d;
            end
        end

        // Operand slices not yet consumed; each stage drops its own slice.
        if (k < LAST) begin : g_ops
            localparam int OW = (STAGES - 1 - k) * SLICE;
            logic [OW-1:0] a_d;
            logic [OW-1:0] b_d;
            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;

            if (k == 0) begin : g_skew
                assign a_d = a[WIDTH-1:SLICE];
                assign b_d = b_eff[WIDTH-1:SLICE];
            end else begin : g_skew
                assign a_d = g_stage[k-1].g_ops.a_q[OW+SLICE-1:SLICE];
                assign b_d = g_stage[k-1].g_ops.b_q[OW+SLICE-1:SLICE];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    // Carry into the MSB equals a^b^sum at that bit, so overflow needs
    // no separate tap inside the slice adder.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[LAST].op_a[SLICE-1]
                   ^ g_stage[LAST].op_b[SLICE-1]
                   ^ g_stage[LAST].add[SLICE-1]
                   ^ g_stage[LAST].add[SLICE];
        end
    end

    assign out_valid = g_stage[LAST].valid_q;
    assign sum       = g_stage[LAST].res_q;
    assign c_out     = g_stage[LAST].carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe_nstage.sv
// tb_add_pipe_nstage: scoreboard bench for add_pipe_nstage
// (32-bit/4-stage instance plus an 8-bit/1-stage instance).

module tb_add_pipe_nstage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        in_valid, in_ready, c_in, sub;
    logic [31:0] a, b, sum;
    logic        out_valid, out_ready, c_out, ovf;

    logic        s_in_valid, s_in_ready, s_c_in, s_sub;
    logic [7:0]  s_a, s_b, s_sum;
    logic        s_out_valid, s_out_ready, s_c_out, s_ovf;

    add_pipe_nstage #(.WIDTH(32), .STAGES(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    add_pipe_nstage #(.WIDTH(8), .STAGES(1)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .c_in(s_c_in), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .c_out(s_c_out), .ovf(s_ovf)
    );

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   last_lat = -1;
    int   last_lat8 = -1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                   input logic ci, input logic sb);
        exp_t        r;
        logic [31:0] bx;
        logic [32:0] t;
        bx    = sb ? ~xb : xb;
        t     = {1'b0, xa} + {1'b0, bx} + {32'd0, (sb | ci)};
        r.sum = t[31:0];
        r.c   = t[32];
        r.v   = (xa[31] == bx[31]) && (t[31] != xa[31]);
        r.acc = 0;
        return r;
    endfunction

    // Monitor: a result transfers on the next rising edge.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", {31'd0, sum, c_out}, 64'd0);
            end else begin
                e = q.pop_front();
                check("result", {30'd0, sum, c_out, ovf}, {30'd0, e.sum, e.c, e.v});
                last_lat = cyc - e.acc;
                pop_cyc.push_back(cyc);
            end
        end
        if (reset_n && s_out_valid && s_out_ready) begin
            if (q8.size() == 0) begin
                check("unexpected_result8", {55'd0, s_sum, s_c_out}, 64'd0);
            end else begin
                e = q8.pop_front();
                check("result8", {54'd0, s_sum, s_c_out, s_ovf},
                      {54'd0, e.sum[7:0], e.c, e.v});
                last_lat8 = cyc - e.acc;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after acceptance.
    task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                        input logic ci, input logic sb, input logic use_model,
                        input logic [31:0] es, input logic ec, input logic ev);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        a = xa; b = xb; c_in = ci; sub = sb;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            if (use_model) e = model(xa, xb, ci, sb);
            else begin
                e.sum = es; e.c = ec; e.v = ev;
            end
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clock); #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (q.size() != 0 || q8.size() != 0)
            check("drain_timeout", 64'(q.size() + q8.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_c_in = 1'b0; s_sub = 1'b0;
        s_out_ready = 1'b1;
        #1;
        check("reset_outputs", {30'd0, sum, c_out, ovf, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_outputs8", {54'd0, s_sum, s_c_out, s_ovf, s_out_valid}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Carry ripples through every slice.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();
        check("latency_4", 64'(last_lat), 64'd4);

        // Subtract with c_in ignored, signed overflow.
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0,
             32'h0001_0000, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0,
             32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0,
             32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream of 16.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1,
                 32'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        check("stream_count", 64'(pop_cyc.size()), 64'd16);
        if (pop_cyc.size() == 16)
            check("stream_consecutive", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);

        // Fill the pipe while output is blocked, then hold 5 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1,
                 32'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            e = q[0];
            check("stall_frozen", {29'd0, out_valid, sum, c_out, ovf},
                  {29'd0, 1'b1, e.sum, e.c, e.v});
            @(posedge clock); #1;
        end
        check("stall_queued", 64'(q.size()), 64'd4);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset", {30'd0, sum, c_out, ovf, out_valid}, 64'd0);
        q.delete();
        #4 reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("no_stale", {63'd0, out_valid}, 64'd0);
            @(posedge clock); #1;
        end

        // Single-stage 8-bit instance.
        s_in_valid = 1'b1; s_a = 8'h7F; s_b = 8'h01; s_c_in = 1'b0; s_sub = 1'b0;
        e.sum = 32'h80; e.c = 1'b0; e.v = 1'b1; e.acc = cyc;
        q8.push_back(e);
        @(posedge clock); #1;
        s_a = 8'h00; s_b = 8'h01; s_sub = 1'b1;
        e.sum = 32'hFF; e.c = 1'b0; e.v = 1'b0; e.acc = cyc;
        q8.push_back(e);
        @(posedge clock); #1;
        s_a = 8'h80; s_b = 8'h80; s_sub = 1'b0;
        e.sum = 32'h00; e.c = 1'b1; e.v = 1'b1; e.acc = cyc;
        q8.push_back(e);
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        drain();
        check("latency_1", 64'(last_lat8), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
